alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Sequences the 16-bit ALU from a queue of commands; owns the A, B and accumulator registers that feed it.
- Accepts {opcode, a, b} commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues each command to the ALU, waits the opcode's latency, captures result and error, and returns them over a valid/ready response port.
- Replaces the testbench-level mux/DFF/load wiring around the ALU with one controller.

Parameters:
- CMD_DEPTH, 4, command FIFO depth; power of 2, at least 2.
- FAST_LAT, 1, ALU settle cycles for single-cycle opcodes; at least 1.
- SLOW_LAT, 3, settle cycles for opcodes 4, 5, 8, 9, 16, 17, 20, 21; at least 1.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command; equals !full.
- cmd_opcode  in  6  ALU opcode (0 clear, 1-12 on A/B, 13-24 on acc/B, 25 no-op).
- cmd_a  in  16  operand A.
- cmd_b  in  16  operand B.
- alu_a  out  16  registered A to ALU.
- alu_b  out  16  registered B to ALU.
- alu_acc  out  16  accumulator to ALU.
- alu_opcode  out  6  opcode to ALU.
- alu_out  in  32  ALU result.
- alu_err  in  1  ALU error.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  32  captured result.
- rsp_err  out  1  captured, qualified error.
- busy  out  1  high when FSM is not IDLE or FIFO is not empty.
- err_sticky  out  1  OR of every rsp_err accepted since reset or last err_clear.
- err_clear  in  1  synchronous clear of err_sticky.

Behaviour:
- Reset values:
  - FIFO empty; FSM in IDLE.
  - alu_a, alu_b, alu_acc, rsp_data = 0.
  - alu_opcode = 25.
  - rsp_valid, rsp_err, err_sticky = 0.
  - cmd_ready = 1; busy = 0.
- FIFO:
  - Push when cmd_valid and cmd_ready.
  - Push and pop in the same cycle are allowed, including when full; count is then unchanged.
  - Pointers wrap modulo CMD_DEPTH.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - alu_opcode = 25.
  - If the FIFO is non-empty: pop, load alu_a, alu_b and alu_opcode from the head entry, set lat_cnt = latency(opcode) - 1, go to WAIT.
  - A command pushed at edge k is popped at edge k+1 at the earliest. No bypass.
- WAIT:
  - Operands and opcode are held.
  - lat_cnt decrements each cycle.
  - On the edge where lat_cnt = 0: capture rsp_data and rsp_err, set rsp_valid, go to RESP.
  - rsp_valid therefore rises after edge k+1+LAT.
- Capture rules:
  - Opcode 0: rsp_data = 0, rsp_err = 0.
  - Opcodes 1-25: rsp_data = alu_out.
  - rsp_err = alu_err only for opcodes 4, 5, 6, 7, 9, 16, 17, 18, 19, 21; otherwise 0.
  - The ALU error output is not cleared between operations, so it must not leak into other opcodes.
  - Opcodes 26-63 are illegal: no ALU wait (LAT treated as 1), rsp_data = 0, rsp_err = 1.
- RESP:
  - Hold rsp_valid, rsp_data and rsp_err stable until rsp_ready.
  - On the accept edge: clear rsp_valid, apply the accumulator update, OR rsp_err into err_sticky, set alu_opcode = 25, go to IDLE.
  - The next pop occurs at the following edge; minimum issue interval is LAT+2 cycles.
- Accumulator update on accept:
  - Opcode 0 → 0.
  - Opcode 25 → unchanged.
  - Illegal opcode → unchanged.
  - Otherwise → alu_out[15:0]; upper bits are truncated.
- err_clear:
  - Clears err_sticky.
  - If an error response is accepted on the same edge, err_sticky ends at 1 (set wins).
- Reset asserted mid-operation: the in-flight command and all queued commands are discarded and every output returns to its reset value immediately (asynchronously).
- cmd_ready is a function of FIFO count only; it does not depend on FSM state.

Test Plan:
- Push {6, 3, 2}, rsp_ready = 1 → rsp_valid after edge k+2, rsp_data = 5, rsp_err = 0, alu_acc = 5 after accept.
- Then push {14, x, x} → rsp_data = 2 (5>>1), alu_acc = 2; then push {0, x, x} → rsp_data = 0, alu_acc = 0.
- Push {7, 3, 20} → rsp_data = 0x0000FFEF, rsp_err = 1, err_sticky = 1; pulse err_clear on the same edge as the next error accept → err_sticky stays 1.
- Push {4, 5, 0} → rsp_valid after SLOW_LAT wait, rsp_data = 120; then {4, 13, 0} → rsp_err = 1. Bench may use a behavioural ALU model with a clearing error output.
- Backpressure: rsp_ready = 0, push 6 commands → 1 in flight + 4 queued, cmd_ready = 0, 6th push held; rsp_valid and rsp_data stable; release rsp_ready → all 5 responses return in push order.
- Push opcode 30 → rsp_err = 1, alu_acc unchanged. Assert reset during WAIT → rsp_valid = 0, busy = 0, alu_opcode = 25, FIFO empty, no response emitted.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command-queue controller for the 16-bit ALU: buffers {opcode, a, b} commands,
// drives the ALU operand/accumulator registers and returns result/error responses.
module alu_cmd_sequencer #(
   parameter int CMD_DEPTH = 4,
   parameter int FAST_LAT  = 1,
   parameter int SLOW_LAT  = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [5:0]  cmd_opcode,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [15:0] alu_acc,
   output logic [5:0]  alu_opcode,
   input  logic [31:0] alu_out,
   input  logic        alu_err,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        busy,
   output logic        err_sticky,
   input  logic        err_clear
);

   localparam int AW      = $clog2(CMD_DEPTH);
   localparam int CW      = AW + 1;
   localparam int MAX_LAT = (SLOW_LAT > FAST_LAT) ? SLOW_LAT : FAST_LAT;
   localparam int LW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam logic [5:0] OP_CLR = 6'd0;
   localparam logic [5:0] OP_NOP = 6'd25;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [15:0] a;
      logic [15:0] b;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   cmd_t            mem [CMD_DEPTH];
   cmd_t            head;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic            full, empty, push;
   logic            pop, done, accept;
   logic [LW-1:0]   lat_cnt;
   logic            illegal;
   state_t          state, state_nxt;

   function automatic logic is_slow(input logic [5:0] op);
      return op inside {6'd4, 6'd5, 6'd8, 6'd9, 6'd16, 6'd17, 6'd20, 6'd21};
   endfunction

   function automatic logic is_err_op(input logic [5:0] op);
      return op inside {6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd16, 6'd17, 6'd18, 6'd19, 6'd21};
   endfunction

   // Illegal opcodes skip the ALU wait entirely (one-cycle latency).
   function automatic logic [LW-1:0] lat_m1(input logic [5:0] op);
      if (op > OP_NOP)  return '0;
      else if (is_slow(op)) return LW'(SLOW_LAT - 1);
      else              return LW'(FAST_LAT - 1);
   endfunction

   assign full      = (count == CW'(CMD_DEPTH));
   assign empty     = (count == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && cmd_ready;
   assign head      = mem[rd_ptr];
   assign busy      = (state != IDLE) || !empty;
   assign illegal   = (alu_opcode > OP_NOP);

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= '{opcode: cmd_opcode, a: cmd_a, b: cmd_b};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: if (!empty) begin
            pop       = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: if (lat_cnt == '0) begin
            done      = 1'b1;
            state_nxt = RESP;
         end
         RESP: if (rsp_ready) begin
            accept    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_acc    <= '0;
         alu_opcode <= OP_NOP;
         lat_cnt    <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         if (pop) begin
            alu_a      <= head.a;
            alu_b      <= head.b;
            alu_opcode <= head.opcode;
            lat_cnt    <= lat_m1(head.opcode);
         end else if (state == WAIT && !done) begin
            lat_cnt <= lat_cnt - 1'b1;
         end
         // The ALU error line is not self-clearing, so mask it to error-capable opcodes.
         if (done) begin
            rsp_valid <= 1'b1;
            rsp_data  <= (alu_opcode == OP_CLR || illegal) ? 32'd0 : alu_out;
            rsp_err   <= illegal || (is_err_op(alu_opcode) && alu_err);
         end
         if (accept) begin
            rsp_valid  <= 1'b0;
            alu_opcode <= OP_NOP;
            if (alu_opcode == OP_CLR)                   alu_acc <= '0;
            else if (alu_opcode != OP_NOP && !illegal)  alu_acc <= alu_out[15:0];
         end
         err_sticky <= (err_sticky && !err_clear) || (accept && rsp_err);
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized scoreboard bench for alu_cmd_sequencer with a latency-aware behavioural ALU.
module tb_alu_cmd_sequencer;

   localparam int CMD_DEPTH = 4;
   localparam int FAST_LAT  = 1;
   localparam int SLOW_LAT  = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid, cmd_ready;
   logic [5:0]  cmd_opcode;
   logic [15:0] cmd_a, cmd_b;
   logic [15:0] alu_a, alu_b, alu_acc;
   logic [5:0]  alu_opcode;
   logic [31:0] alu_out;
   logic        alu_err;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err, busy, err_sticky, err_clear;

   alu_cmd_sequencer #(.CMD_DEPTH(CMD_DEPTH), .FAST_LAT(FAST_LAT), .SLOW_LAT(SLOW_LAT)) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_acc(alu_acc), .alu_opcode(alu_opcode),
      .alu_out(alu_out), .alu_err(alu_err),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .busy(busy), .err_sticky(err_sticky), .err_clear(err_clear)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic [15:0] acc;
   } exp_t;

   exp_t        exp_q[$];
   int          tests = 0;
   int          fails = 0;
   logic [15:0] model_acc = '0;
   logic        sticky_m = 1'b0;

   // Behavioural ALU; non-error opcodes drive junk on the error line to expose leaks.
   function automatic logic [32:0] alu_f(input logic [5:0] op, input logic [15:0] a, b, acc);
      logic [31:0] x, y, r;
      logic        e;
      int          sub;
      x   = (op >= 13 && op <= 24) ? {16'h0, acc} : {16'h0, a};
      y   = {16'h0, b};
      sub = (op >= 13 && op <= 24) ? int'(op) - 12 : int'(op);
      e   = a[0];
      r   = '0;
      if (op == 0) begin r = '0; e = 1'b1; end
      else if (op == 25) begin r = {16'h5A5A, acc}; e = 1'b1; end
      else if (op > 25) begin r = 32'hDEADBEEF; e = 1'b0; end
      else case (sub)
         1:  r = x & y;
         2:  r = x >> 1;
         3:  r = x ^ y;
         4:  begin e = (x > 12); r = 1; if (!e) for (int i = 2; i <= int'(x); i++) r = r * i; else r = '0; end
         5:  begin r = x * y; e = (r > 32'hFFFF); end
         6:  begin r = x + y; e = (r > 32'hFFFF); end
         7:  begin r = {16'h0, x[15:0] - y[15:0]}; e = (x < y); end
         8:  r = x << y[3:0];
         9:  begin e = (y == 0); r = (y == 0) ? 32'd0 : x / y; end
         10: r = x | y;
         11: r = {16'h0, ~x[15:0]};
         12: r = x + 1;
         default: r = '0;
      endcase
      return {e, r};
   endfunction

   // Output only valid once inputs have been stable for the opcode's settle time.
   logic [53:0] last_in = '0;
   int          age = 0;
   always @(negedge clock) begin
      if ({alu_opcode, alu_a, alu_b, alu_acc} != last_in) begin
         last_in <= {alu_opcode, alu_a, alu_b, alu_acc};
         age     <= 1;
      end else if (age < 1000) begin
         age <= age + 1;
      end
   end

   always_comb begin
      logic [32:0] f;
      int          settle;
      f       = alu_f(alu_opcode, alu_a, alu_b, alu_acc);
      settle  = (alu_opcode inside {6'd4, 6'd5, 6'd8, 6'd9, 6'd16, 6'd17, 6'd20, 6'd21}) ? SLOW_LAT : FAST_LAT;
      alu_out = f[31:0];
      alu_err = f[32];
      if (age < settle) begin
         alu_out = 32'hBAD0BAD0;
         alu_err = 1'b1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Monitor: compares every presented response against the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset) begin
            exp_q.delete();
            sticky_m = 1'b0;
         end else begin
            check("err_sticky", {31'd0, err_sticky}, {31'd0, sticky_m});
            if (rsp_valid) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL spurious_rsp: got data 0x%0h, want no response", rsp_data);
               end else begin
                  e = exp_q[0];
                  check("rsp_data", rsp_data, e.data);
                  check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                  check("alu_acc_during_op", {16'd0, alu_acc}, {16'd0, e.acc});
                  if (rsp_ready) begin
                     sticky_m = (sticky_m && !err_clear) || e.err;
                     void'(exp_q.pop_front());
                  end else if (err_clear) sticky_m = 1'b0;
               end
            end else if (err_clear) sticky_m = 1'b0;
         end
      end
   end

   task automatic push(input logic [5:0] op, input logic [15:0] a, b, input bit rnd);
      exp_t        e;
      logic [32:0] f;
      int          n;
      n          = 0;
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      cmd_valid  = 1'b1;
      forever begin
         @(negedge clock);
         if (cmd_ready) break;
         n++;
         if (n > 500) begin fail_now("push_timeout"); break; end
         @(posedge clock);
         #1;
         if (rnd) begin
            rsp_ready = ($urandom % 4) != 0;
            err_clear = ($urandom % 16) == 0;
         end
      end
      @(posedge clock);
      f     = alu_f(op, a, b, model_acc);
      e.acc = model_acc;
      if (op == 0) begin
         e.data = '0; e.err = 1'b0; model_acc = '0;
      end else if (op > 25) begin
         e.data = '0; e.err = 1'b1;
      end else begin
         e.data = f[31:0];
         e.err  = (op inside {6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd16, 6'd17, 6'd18, 6'd19, 6'd21}) ? f[32] : 1'b0;
         if (op != 25) model_acc = f[15:0];
      end
      exp_q.push_back(e);
      #1;
      cmd_valid = 1'b0;
      if (rnd) begin
         rsp_ready = ($urandom % 4) != 0;
         err_clear = ($urandom % 16) == 0;
      end
   endtask

   task automatic drain();
      int n;
      n         = 0;
      rsp_ready = 1'b1;
      err_clear = 1'b0;
      do begin
         @(negedge clock);
         n++;
      end while ((exp_q.size() != 0 || busy) && n < 3000);
      if (n >= 3000) fail_now("drain_timeout");
      @(posedge clock);
      #1;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!rsp_valid && n < 100);
      if (n >= 100) fail_now("wait_valid_timeout");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0]  op;
      logic [15:0] a, b;
      cmd_valid  = 1'b0;
      cmd_opcode = '0;
      cmd_a      = '0;
      cmd_b      = '0;
      rsp_ready  = 1'b1;
      err_clear  = 1'b0;
      #2 reset = 1'b1;
      #2;
      check("rst_alu_opcode", {26'd0, alu_opcode}, 32'd25);
      check("rst_alu_a", {16'd0, alu_a}, 32'd0);
      check("rst_alu_b", {16'd0, alu_b}, 32'd0);
      check("rst_alu_acc", {16'd0, alu_acc}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b0;

      // add, fast latency: response visible after edge k+2
      push(6'd6, 16'd3, 16'd2, 0);
      @(negedge clock);
      @(negedge clock);
      check("lat_fast_k1", {31'd0, rsp_valid}, 32'd0);
      @(negedge clock);
      check("lat_fast_k2", {31'd0, rsp_valid}, 32'd1);
      drain();
      check("acc_after_add", {16'd0, alu_acc}, 32'd5);
      push(6'd14, 16'($urandom), 16'($urandom), 0);
      drain();
      check("acc_after_shr", {16'd0, alu_acc}, 32'd2);
      push(6'd0, 16'($urandom), 16'($urandom), 0);
      drain();
      check("acc_after_clear", {16'd0, alu_acc}, 32'd0);

      // error path and err_clear colliding with an error accept
      push(6'd7, 16'd3, 16'd20, 0);
      drain();
      check("sticky_after_sub_err", {31'd0, err_sticky}, 32'd1);
      rsp_ready = 1'b0;
      push(6'd7, 16'd1, 16'd2, 0);
      wait_valid();
      @(posedge clock);
      #1 err_clear = 1'b1;
      rsp_ready = 1'b1;
      @(posedge clock);
      #1 err_clear = 1'b0;
      @(negedge clock);
      check("sticky_set_wins", {31'd0, err_sticky}, 32'd1);
      @(posedge clock);
      #1 err_clear = 1'b1;
      @(posedge clock);
      #1 err_clear = 1'b0;
      @(negedge clock);
      check("sticky_cleared", {31'd0, err_sticky}, 32'd0);
      @(posedge clock);
      #1;

      // slow opcode latency
      push(6'd4, 16'd5, 16'd0, 0);
      repeat (4) @(negedge clock);
      check("lat_slow_k3", {31'd0, rsp_valid}, 32'd0);
      @(negedge clock);
      check("lat_slow_k4", {31'd0, rsp_valid}, 32'd1);
      drain();
      check("acc_after_fact", {16'd0, alu_acc}, 32'd120);
      push(6'd4, 16'd13, 16'd0, 0);
      drain();
      check("sticky_after_fact_ovf", {31'd0, err_sticky}, 32'd1);

      // backpressure: one in flight, four queued, sixth held off
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(6'd6, 16'(i), 16'd1, 0);
      @(negedge clock);
      check("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("full_busy", {31'd0, busy}, 32'd1);
      @(posedge clock);
      #1;
      cmd_opcode = 6'd6;
      cmd_a      = 16'd5;
      cmd_b      = 16'd1;
      cmd_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("held_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      end
      @(posedge clock);
      #1 rsp_ready = 1'b1;
      push(6'd6, 16'd5, 16'd1, 0);
      drain();
      check("acc_after_backpressure", {16'd0, alu_acc}, 32'd6);

      // illegal opcode leaves the accumulator alone
      push(6'd30, 16'd1, 16'd2, 0);
      drain();
      check("acc_after_illegal", {16'd0, alu_acc}, 32'd6);

      // reset during WAIT discards everything
      push(6'd4, 16'd5, 16'd0, 0);
      push(6'd6, 16'd1, 16'd1, 0);
      push(6'd6, 16'd2, 16'd2, 0);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_alu_opcode", {26'd0, alu_opcode}, 32'd25);
      check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("mid_rst_alu_acc", {16'd0, alu_acc}, 32'd0);
      check("mid_rst_err_sticky", {31'd0, err_sticky}, 32'd0);
      @(negedge clock);
      @(posedge clock);
      #1 reset = 1'b0;
      model_acc = '0;
      repeat (10) @(negedge clock);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(posedge clock);
      #1;

      // randomized traffic with random backpressure and err_clear pulses
      for (int n = 0; n < 250; n++) begin
         if ($urandom % 4 == 0) begin
            @(posedge clock);
            #1;
         end
         op = ($urandom % 8 == 0) ? 6'(26 + $urandom % 38) : 6'($urandom % 26);
         a  = ($urandom % 2 != 0) ? 16'($urandom % 16) : 16'($urandom);
         b  = ($urandom % 2 != 0) ? 16'($urandom % 16) : 16'($urandom);
         rsp_ready = ($urandom % 4) != 0;
         err_clear = ($urandom % 16) == 0;
         push(op, a, b, 1);
      end
      drain();
      check("final_busy", {31'd0, busy}, 32'd0);
      check("final_acc", {16'd0, alu_acc}, {16'd0, model_acc});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
